// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle for booth_mult_seq.
// Optional port is_signed exists only when BOOTH_UNSIGNED_EN is defined.
interface booth_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;
`ifdef BOOTH_UNSIGNED_EN
    logic               is_signed;

    modport master (
        output in_valid, multiplicand, multiplier, out_ready, is_signed,
        input  in_ready, out_valid, product, busy
    );
    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready, is_signed,
        output in_ready, out_valid, product, busy
    );
`else
    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product, busy
    );
    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product, busy
    );
`endif
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one operand pair per handshake,
// two cycles (ADD, SHIFT) per multiplier bit, result held until consumed.
// Optional feature macro: BOOTH_UNSIGNED_EN adds is_signed; unsigned operands
// are zero-extended by one bit and take one extra iteration.
module booth_mult_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)  // derived, do not override
) (
    input  logic            clk,
    input  logic            rst_n,
    booth_mult_seq_if.slave bus
);

`ifdef BOOTH_UNSIGNED_EN
    localparam int QW = WIDTH + 1;  // room for a zero-extended unsigned multiplier
`else
    localparam int QW = WIDTH;
`endif
    // one guard bit on A/M so A-M cannot overflow for M = most negative value
    localparam int AW = QW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    a_q, m_q;
    logic [QW-1:0]    q_q;
    logic             q1_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last_cnt;
    logic             accept;

    // in_ready is forced low while reset is held, even though state reads IDLE
    assign bus.in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & bus.out_ready));
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);

`ifdef BOOTH_UNSIGNED_EN
    logic sgn_q;
    logic ext_m, ext_q;

    assign ext_m = bus.is_signed & bus.multiplicand[WIDTH-1];
    assign ext_q = bus.is_signed & bus.multiplier[WIDTH-1];

    // Latch the operation mode: signed runs WIDTH iterations, unsigned WIDTH+1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_q    <= 1'b0;
            last_cnt <= '0;
        end else if (accept) begin
            sgn_q    <= bus.is_signed;
            last_cnt <= bus.is_signed ? CNT_W'(WIDTH - 1) : CNT_W'(WIDTH);
        end
    end

    // Signed mode leaves the unprocessed extension bit in Q[0]; skip it
    assign bus.product = sgn_q ? {a_q[WIDTH-1:0], q_q[QW-1:1]}
                               : {a_q[WIDTH-2:0], q_q};
`else
    assign last_cnt    = CNT_W'(WIDTH - 1);
    assign bus.product = {a_q[WIDTH-1:0], q_q};
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: ADD/SHIFT alternate per iteration, DONE waits for the consumer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ADD;
            ADD:     state_nxt = SHIFT;
            SHIFT:   state_nxt = (count == last_cnt) ? DONE : ADD;
            DONE: begin
                if (accept)             state_nxt = ADD;
                else if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Booth datapath: load on accept, add/subtract in ADD, arithmetic shift in SHIFT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            m_q   <= '0;
            q_q   <= '0;
            q1_q  <= 1'b0;
            count <= '0;
        end else if (accept) begin
`ifdef BOOTH_UNSIGNED_EN
            m_q <= {{2{ext_m}}, bus.multiplicand};
            q_q <= {ext_q, bus.multiplier};
`else
            m_q <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
            q_q <= bus.multiplier;
`endif
            a_q   <= '0;
            q1_q  <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                ADD: begin
                    case ({q_q[0], q1_q})
                        2'b01:   a_q <= a_q + m_q;
                        2'b10:   a_q <= a_q - m_q;
                        default: a_q <= a_q;
                    endcase
                end
                SHIFT: begin
                    {a_q, q_q, q1_q} <= {a_q[AW-1], a_q, q_q};
                    count            <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
